// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ==========================================================================
// regfile_wb_arbiter: shares the register-file write port between ALU
// write-back and a FIFO of long-latency results. Optional macro: WB_PERF_EN.
// Revision: 1.0
// ==========================================================================
module regfile_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        alu_we_i,
  input  logic [4:0]  alu_addr_i,
  input  logic [31:0] alu_data_i,
  input  logic        lu_valid_i,
  input  logic [4:0]  lu_addr_i,
  input  logic [31:0] lu_data_i,
  output logic        lu_ready_o,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_addr_i,
  output logic        RegWrite_o,
  output logic [4:0]  RDaddr_o,
  output logic [31:0] RDdata_o,
  output logic [31:0] busy_o,
  output logic        stall_o,
  output logic [31:0] perf_conflict_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SW    = $clog2(STARVE_MAX + 1);
  localparam logic [PTR_W:0] FULL_CNT   = (PTR_W + 1)'(DEPTH);
  localparam logic [SW-1:0]  STARVE_LIM = SW'(STARVE_MAX);

  logic [4:0]  addr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [SW-1:0]    starve, starve_next;
  logic [31:0]      busy, busy_next;

  logic        full, empty, push, pop;
  logic        sel_valid, sel_we;
  logic [4:0]  sel_addr, head_addr;
  logic [31:0] sel_data, head_data;

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign lu_ready_o = !full;
  assign push       = lu_valid_i && !full;
  // The pop decision uses pre-edge occupancy, so a same-cycle push is never popped.
  assign pop        = !alu_we_i && !empty;
  assign head_addr  = addr_mem[rd_ptr];
  assign head_data  = data_mem[rd_ptr];

  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = RDaddr_o;
    sel_data  = RDdata_o;
    if (alu_we_i) begin
      sel_valid = 1'b1;
      sel_addr  = alu_addr_i;
      sel_data  = alu_data_i;
    end else if (pop) begin
      sel_valid = 1'b1;
      sel_addr  = head_addr;
      sel_data  = head_data;
    end
    sel_we = sel_valid && (sel_addr != 5'd0);
  end

  always_comb begin
    busy_next = busy;
    if (pop) busy_next[head_addr] = 1'b0;
    if (issue_valid_i) busy_next[issue_addr_i] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    starve_next = starve;
    if (pop || empty) starve_next = '0;
    else if (alu_we_i && starve != STARVE_LIM) starve_next = starve + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_ptr] <= lu_addr_i;
      data_mem[wr_ptr] <= lu_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      RegWrite_o <= 1'b0;
      RDaddr_o   <= 5'd0;
      RDdata_o   <= 32'd0;
      busy       <= 32'd0;
      starve     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      RegWrite_o <= sel_we;
      RDaddr_o   <= sel_addr;
      RDdata_o   <= sel_data;
      busy       <= busy_next;
      starve     <= starve_next;
    end
  end

  assign busy_o  = busy;
  assign stall_o = (starve == STARVE_LIM);

`ifdef WB_PERF_EN
  logic [31:0] perf_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i)                     perf_cnt <= 32'd0;
    else if (alu_we_i && !empty)   perf_cnt <= perf_cnt + 32'd1;
  end
  assign perf_conflict_o = perf_cnt;
`else
  assign perf_conflict_o = 32'd0;
`endif

`ifndef SYNTHESIS
  // Upstream must bubble ALU write-back while stall is raised.
  a_stall_contract: assert property (@(posedge clk_i) disable iff (rst_i)
                                     !(stall_o && alu_we_i));
`endif

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-back controller for the 32x32 register file's single write port. It shares that port between the in-order ALU pipeline write-back, which has fixed priority and no backpressure, and a long-latency unit (LU: load/mul/div), which is buffered in a small FIFO. It also keeps a busy scoreboard of LU-pending destination registers for the hazard logic, and suppresses writes to register 0.

Parameters:
DEPTH, 4, LU write FIFO entries; power of 2, minimum 2.
STARVE_MAX, 8, consecutive cycles a non-empty FIFO may lose to the ALU before stall_o is raised.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  reset; synchronous, active-high.
alu_we_i  in  1  ALU write-back valid; always accepted.
alu_addr_i  in  5  ALU destination register.
alu_data_i  in  32  ALU write data.
lu_valid_i  in  1  LU write request.
lu_addr_i  in  5  LU destination register.
lu_data_i  in  32  LU write data.
lu_ready_o  out  1  FIFO can accept; push occurs when lu_valid_i && lu_ready_o.
issue_valid_i  in  1  an LU op is issued; marks its destination busy.
issue_addr_i  in  5  destination of the issued LU op.
RegWrite_o  out  1  register file write enable (registered).
RDaddr_o  out  5  register file write address (registered).
RDdata_o  out  32  register file write data (registered).
busy_o  out  32  scoreboard; bit n = register n has a pending LU write.
stall_o  out  1  request to upstream to bubble ALU write-back.
perf_conflict_o  out  32  conflict counter (see Optional Feature).

Behaviour:
- Reset values: RegWrite_o=0, RDaddr_o=0, RDdata_o=0, FIFO empty, busy_o=0, stall_o=0, starve counter=0, perf_conflict_o=0. lu_ready_o=1 once rst_i drops.
- Reset mid-operation discards all FIFO contents and scoreboard bits. No write is issued in the cycle after rst_i is high.
- lu_ready_o = !full and depends only on occupancy. A push is refused when full, even if a pop occurs in the same cycle.
- Per-cycle selection, with the result registered onto RegWrite_o, RDaddr_o and RDdata_o at the next edge:
  - alu_we_i=1: ALU wins.
  - otherwise, FIFO non-empty: pop the head.
  - otherwise: RegWrite_o=0.
- Latency:
  - ALU input at cycle N appears on RegWrite_o at N+1.
  - LU push at N is earliest poppable at N+1 and appears at N+2; there is no fall-through.
- Register 0: any selected write with address 0 (ALU or FIFO pop) yields RegWrite_o=0. A FIFO entry addressed to 0 is still popped.
- FIFO order is strict FIFO. Pointers wrap modulo DEPTH. Count is tracked with an extra bit so full and empty are distinguished.
- Simultaneous push and pop (not full): occupancy is unchanged. Push and pop on an empty FIFO cannot pop the new entry in that cycle.
- Scoreboard:
  - issue_valid_i sets busy[issue_addr_i].
  - A FIFO pop clears busy[head addr].
  - Set and clear of the same register in one cycle: set wins.
  - busy_o[0] is always 0.
  - ALU writes never touch the scoreboard.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and alu_we_i=1.
  - It clears on any pop or when the FIFO is empty.
  - It saturates at STARVE_MAX.
  - stall_o = (counter == STARVE_MAX), driven from the registered counter.
- Upstream contract: alu_we_i=0 in every cycle stall_o=1. If violated, the ALU still wins and the counter holds at STARVE_MAX. Simulation-only assertion flags the violation.

Optional Feature:
WB_PERF_EN:
- Defined: perf_conflict_o is a 32-bit wrapping counter. It increments each cycle alu_we_i=1 && FIFO non-empty, and clears on rst_i.
- Undefined: perf_conflict_o is tied to 0 and no counter logic is built. The port is present in both cases.

Test Plan:
- ALU-only: alu_we_i=1, addr 5, data 0xDEADBEEF at cycle N -> RegWrite_o=1, RDaddr_o=5, RDdata_o=0xDEADBEEF at N+1; busy_o unchanged.
- LU path with scoreboard: issue_valid_i addr 9, then LU push addr 9, data 0x1234 with ALU idle -> busy_o[9]=1 from the next cycle; write of 9/0x1234 at push+2; busy_o[9]=0 the cycle after the pop.
- Fill and order: DEPTH=4, push 4 LU writes (addr 1..4) while alu_we_i=1 -> lu_ready_o=0 after the 4th push; a 5th push is refused. After ALU release, writes emerge in order 1,2,3,4 on consecutive cycles; lu_ready_o returns to 1 after the first pop.
- Starvation: FIFO holds 1 entry, alu_we_i=1 for 8 cycles -> stall_o=1 on the 9th cycle. Drop alu_we_i -> entry written, stall_o=0 the next cycle.
- Zero register: ALU write to addr 0, and LU entry to addr 0 -> RegWrite_o stays 0 in both cases; the FIFO entry is still consumed.
- Reset mid-operation: 3 FIFO entries plus busy bits set, assert rst_i for one cycle -> RegWrite_o=0, busy_o=0, lu_ready_o=1 afterwards. With WB_PERF_EN, perf_conflict_o=0 after reset and equal to the conflict cycles counted in the starvation test.
